// File: rtl/decode_pkg.sv
// Shared types for the decode queue: opcode classes, control encodings and
// the registered per-slot control bundle handed to dispatch.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (affects decoder and queue).
package decode_pkg;

  localparam int DEC_XLEN = 32;
  localparam logic [1:0] ALUOP_DEFAULT = 2'b11;

  typedef enum logic [3:0] {
    OP_R     = 4'b0000,
    OP_I     = 4'b0001,
    OP_S     = 4'b0010,
    OP_B     = 4'b0011,
    OP_U     = 4'b0100,
    OP_JAL   = 4'b0101,
    OP_U_ALT = 4'b0110,
    OP_JALR  = 4'b0111,
    OP_LOAD  = 4'b1000
  } opcode_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100,
    IMM_R = 3'b111
  } imm_src_e;

  typedef enum logic [1:0] {
    ALU_OP_RI    = 2'b00,
    ALU_OP_MEMBR = 2'b01,
    ALU_OP_RSVD  = 2'b10,
    ALU_OP_NONE  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic [DEC_XLEN-1:0] pc;
    logic [DEC_XLEN-1:0] instr;
    imm_src_e            immSrc;
    alu_op_e             aluOp;
    logic                memWrite;
    logic                branch;
    logic                jump;
    logic                illegal;
  } dec_bundle_t;

endpackage

// File: rtl/decode_queue_instr_class_decode.sv
// Combinational single-instruction class decoder producing one control bundle.
// DECODE_ILLEGAL_TRAP_EN: when defined, unknown opcodes raise the illegal flag;
// otherwise they decode to the defaults with illegal held at 0.
module instr_class_decode
  import decode_pkg::*;
(
  input  logic [DEC_XLEN-1:0] instr,
  input  logic [DEC_XLEN-1:0] pc,
  output dec_bundle_t         bundle
);

  // Start from the default bundle and override per opcode class
  always_comb begin
    bundle.pc       = pc;
    bundle.instr    = instr;
    bundle.immSrc   = IMM_I;
    bundle.aluOp    = alu_op_e'(ALUOP_DEFAULT);
    bundle.memWrite = 1'b0;
    bundle.branch   = 1'b0;
    bundle.jump     = 1'b0;
    bundle.illegal  = 1'b0;
    case (instr[3:0])
      OP_R: begin
        bundle.aluOp  = ALU_OP_RI;
        bundle.immSrc = IMM_R;
      end
      OP_I: bundle.aluOp = ALU_OP_RI;
      OP_S: begin
        bundle.aluOp    = ALU_OP_MEMBR;
        bundle.immSrc   = IMM_S;
        bundle.memWrite = 1'b1;
      end
      OP_B: begin
        bundle.aluOp  = ALU_OP_MEMBR;
        bundle.immSrc = IMM_B;
        bundle.branch = 1'b1;
      end
      OP_U, OP_U_ALT: bundle.immSrc = IMM_U;
      OP_JAL: begin
        bundle.immSrc = IMM_J;
        bundle.jump   = 1'b1;
      end
      OP_JALR: bundle.jump = 1'b1;
      OP_LOAD: bundle.aluOp = ALU_OP_MEMBR;
      default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        bundle.illegal = 1'b1;
`else
        bundle.illegal = 1'b0;
`endif
      end
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// Multi-slot decode stage: circular instruction queue fed by fetch, with a
// registered output stage holding up to WIDTH decoded bundles for dispatch.
// DECODE_ILLEGAL_TRAP_EN: when defined, a load stops at the first illegal slot
// and the output stage stops loading until flush.
// XLEN must match decode_pkg::DEC_XLEN since the bundle struct is fixed-width.
module decode_queue
  import decode_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8,
  parameter int XLEN  = DEC_XLEN
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      fetch_valid,
  input  logic [WIDTH*XLEN-1:0] fetch_instr,
  input  logic [WIDTH*XLEN-1:0] fetch_pc,
  output logic                  fetch_ready,
  output logic [WIDTH-1:0]      dec_valid,
  output logic [WIDTH*XLEN-1:0] dec_pc,
  output logic [WIDTH*XLEN-1:0] dec_instr,
  output logic [WIDTH*3-1:0]    dec_immSrc,
  output logic [WIDTH*2-1:0]    dec_aluOp,
  output logic [WIDTH-1:0]      dec_memWrite,
  output logic [WIDTH-1:0]      dec_branch,
  output logic [WIDTH-1:0]      dec_jump,
  output logic [WIDTH-1:0]      dec_illegal,
  input  logic                  dispatch_ready
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam logic [CNTW-1:0] READY_MAX = CNTW'(DEPTH - WIDTH);
  localparam logic [CNTW-1:0] WIDTH_C   = CNTW'(WIDTH);

  logic [XLEN-1:0] ram_instr [DEPTH];
  logic [XLEN-1:0] ram_pc    [DEPTH];
  logic [PTRW-1:0] head, tail;
  logic [CNTW-1:0] count, push_cnt, avail, load_cnt;
  logic            push_en, load_en;
  logic [XLEN-1:0] cand_instr [WIDTH];
  logic [XLEN-1:0] cand_pc    [WIDTH];
  dec_bundle_t     cand  [WIDTH];
  dec_bundle_t     stage [WIDTH];
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic            halted;
`endif

  assign fetch_ready = (count <= READY_MAX);
  assign push_en     = fetch_ready && !flush && reset_n;

  // Number of fetch slots accepted this cycle (valid is a thermometer)
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (fetch_valid[i]) push_cnt = push_cnt + CNTW'(1);
    end
    if (!fetch_ready) push_cnt = '0;
  end

  // Present the WIDTH oldest entries to the decoders; pointer math wraps at DEPTH
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cand_instr[i] = ram_instr[head + PTRW'(i)];
      cand_pc[i]    = ram_pc[head + PTRW'(i)];
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_decode
    instr_class_decode u_decode (
      .instr  (cand_instr[g]),
      .pc     (cand_pc[g]),
      .bundle (cand[g])
    );
  end

  // Decide whether the output stage loads and how many entries it takes
  always_comb begin
    avail    = (count < WIDTH_C) ? count : WIDTH_C;
    load_cnt = avail;
`ifdef DECODE_ILLEGAL_TRAP_EN
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if ((CNTW'(i) < avail) && cand[i].illegal) load_cnt = CNTW'(i + 1);
    end
    load_en = ((dec_valid == '0) || dispatch_ready) && !halted;
`else
    load_en = (dec_valid == '0) || dispatch_ready;
`endif
    if (!load_en) load_cnt = '0;
  end

  // Queue storage, written in slot order starting at tail
  always_ff @(posedge clk) begin
    if (push_en) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (fetch_valid[i]) begin
          ram_instr[tail + PTRW'(i)] <= fetch_instr[i*XLEN +: XLEN];
          ram_pc[tail + PTRW'(i)]    <= fetch_pc[i*XLEN +: XLEN];
        end
      end
    end
  end

  // Pointers, occupancy and the registered output stage; flush beats push/pop
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      dec_valid <= '0;
      for (int i = 0; i < WIDTH; i++) stage[i] <= '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      halted    <= 1'b0;
`endif
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      dec_valid <= '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      halted    <= 1'b0;
`endif
    end else begin
      tail  <= tail + PTRW'(push_cnt);
      head  <= head + PTRW'(load_cnt);
      count <= count + push_cnt - load_cnt;
`ifdef DECODE_ILLEGAL_TRAP_EN
      if (halted && dispatch_ready) dec_valid <= '0;
`endif
      if (load_en) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (CNTW'(i) < load_cnt) begin
            dec_valid[i] <= 1'b1;
            stage[i]     <= cand[i];
`ifdef DECODE_ILLEGAL_TRAP_EN
            if (cand[i].illegal) halted <= 1'b1;
`endif
          end else begin
            dec_valid[i] <= 1'b0;
            stage[i]     <= '0;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_out
    assign dec_pc[g*XLEN +: XLEN]    = stage[g].pc;
    assign dec_instr[g*XLEN +: XLEN] = stage[g].instr;
    assign dec_immSrc[g*3 +: 3]      = stage[g].immSrc;
    assign dec_aluOp[g*2 +: 2]       = stage[g].aluOp;
    assign dec_memWrite[g]           = stage[g].memWrite;
    assign dec_branch[g]             = stage[g].branch;
    assign dec_jump[g]               = stage[g].jump;
    assign dec_illegal[g]            = stage[g].illegal;
  end

endmodule

// File: tb/tb_decode_queue.sv
// Testbench for decode_queue: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based reference model.
// Honours DECODE_ILLEGAL_TRAP_EN the same way the design does.
module tb_decode_queue;

  localparam int WIDTH = 2;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  logic                  clk;
  logic                  reset_n;
  logic                  flush;
  logic [WIDTH-1:0]      fetch_valid;
  logic [WIDTH*XLEN-1:0] fetch_instr;
  logic [WIDTH*XLEN-1:0] fetch_pc;
  logic                  fetch_ready;
  logic [WIDTH-1:0]      dec_valid;
  logic [WIDTH*XLEN-1:0] dec_pc;
  logic [WIDTH*XLEN-1:0] dec_instr;
  logic [WIDTH*3-1:0]    dec_immSrc;
  logic [WIDTH*2-1:0]    dec_aluOp;
  logic [WIDTH-1:0]      dec_memWrite;
  logic [WIDTH-1:0]      dec_branch;
  logic [WIDTH-1:0]      dec_jump;
  logic [WIDTH-1:0]      dec_illegal;
  logic                  dispatch_ready;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } ent_t;

  ent_t            mq[$];
  ent_t            exp_slot[WIDTH];
  int              exp_n       = 0;
  bit              exp_halt    = 1'b0;
  bit              live        = 1'b0;
  bit              after_reset = 1'b0;
  logic [XLEN-1:0] pc_ctr      = 32'h0000_1000;

  decode_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .flush          (flush),
    .fetch_valid    (fetch_valid),
    .fetch_instr    (fetch_instr),
    .fetch_pc       (fetch_pc),
    .fetch_ready    (fetch_ready),
    .dec_valid      (dec_valid),
    .dec_pc         (dec_pc),
    .dec_instr      (dec_instr),
    .dec_immSrc     (dec_immSrc),
    .dec_aluOp      (dec_aluOp),
    .dec_memWrite   (dec_memWrite),
    .dec_branch     (dec_branch),
    .dec_jump       (dec_jump),
    .dec_illegal    (dec_illegal),
    .dispatch_ready (dispatch_ready)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit isIllegal(input logic [3:0] op);
`ifdef DECODE_ILLEGAL_TRAP_EN
    return op >= 4'h9;
`else
    return 1'b0;
`endif
  endfunction

  // Expected controls from the opcode table: {illegal, jump, branch, memWrite, aluOp[1:0], immSrc[2:0]}
  function automatic logic [8:0] expFields(input logic [3:0] op);
    logic [1:0] alu = 2'b11;
    logic [2:0] imm = 3'b000;
    logic       mw  = 1'b0;
    logic       br  = 1'b0;
    logic       jp  = 1'b0;
    case (op)
      4'h0: begin alu = 2'b00; imm = 3'b111; end
      4'h1: alu = 2'b00;
      4'h2: begin alu = 2'b01; imm = 3'b001; mw = 1'b1; end
      4'h3: begin alu = 2'b01; imm = 3'b010; br = 1'b1; end
      4'h4, 4'h6: imm = 3'b011;
      4'h5: begin imm = 3'b100; jp = 1'b1; end
      4'h7: jp = 1'b1;
      4'h8: alu = 2'b01;
      default: ;
    endcase
    return {isIllegal(op), jp, br, mw, alu, imm};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst_n, input logic fl, input logic dr,
                               input logic [WIDTH-1:0] v, input logic [3:0] op0, input logic [3:0] op1);
    logic [XLEN-1:0] r0, r1;
    r0 = $urandom();
    r1 = $urandom();
    r0[3:0] = op0;
    r1[3:0] = op1;
    reset_n        = rst_n;
    flush          = fl;
    dispatch_ready = dr;
    fetch_valid    = v;
    fetch_instr    = {r1, r0};
    fetch_pc       = {pc_ctr + 32'd4, pc_ctr};
    pc_ctr         = pc_ctr + 32'd8;
    @(negedge clk);
  endtask

  // Reference model: advance on each rising edge from the inputs the bench drove
  always @(posedge clk) begin : model
    int n;
    bit rdy;
    if (!reset_n) begin
      mq.delete();
      exp_n       = 0;
      exp_halt    = 1'b0;
      live        = 1'b1;
      after_reset = 1'b1;
      for (int i = 0; i < WIDTH; i++) exp_slot[i] = '{pc: '0, instr: '0};
    end else begin
      after_reset = 1'b0;
      if (flush) begin
        mq.delete();
        exp_n    = 0;
        exp_halt = 1'b0;
      end else begin
        rdy = (DEPTH - mq.size()) >= WIDTH;
        if (!exp_halt && (exp_n == 0 || dispatch_ready)) begin
          n = (mq.size() < WIDTH) ? mq.size() : WIDTH;
          for (int k = 0; k < n; k++) begin
            if (isIllegal(mq[k].instr[3:0])) begin
              n = k + 1;
              break;
            end
          end
          for (int k = 0; k < n; k++) exp_slot[k] = mq.pop_front();
          exp_n = n;
          if (n > 0 && isIllegal(exp_slot[n-1].instr[3:0])) exp_halt = 1'b1;
        end else if (exp_halt && dispatch_ready) begin
          exp_n = 0;
        end
        if (rdy) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (fetch_valid[i]) mq.push_back('{pc: fetch_pc[i*XLEN +: XLEN], instr: fetch_instr[i*XLEN +: XLEN]});
          end
        end
      end
    end
  end

  // Compare DUT outputs against the model on every falling edge once reset has been seen
  always @(negedge clk) begin : compare
    logic [WIDTH-1:0] ev;
    logic [8:0]       f;
    if (live) begin
      ev = '0;
      for (int k = 0; k < exp_n; k++) ev[k] = 1'b1;
      checkOutput("fetch_ready", 64'(fetch_ready), 64'((DEPTH - mq.size()) >= WIDTH));
      checkOutput("dec_valid", 64'(dec_valid), 64'(ev));
      for (int i = 0; i < exp_n; i++) begin
        f = expFields(exp_slot[i].instr[3:0]);
        checkOutput($sformatf("dec_pc[%0d]", i), 64'(dec_pc[i*XLEN +: XLEN]), 64'(exp_slot[i].pc));
        checkOutput($sformatf("dec_instr[%0d]", i), 64'(dec_instr[i*XLEN +: XLEN]), 64'(exp_slot[i].instr));
        checkOutput($sformatf("dec_immSrc[%0d]", i), 64'(dec_immSrc[i*3 +: 3]), 64'(f[2:0]));
        checkOutput($sformatf("dec_aluOp[%0d]", i), 64'(dec_aluOp[i*2 +: 2]), 64'(f[4:3]));
        checkOutput($sformatf("dec_memWrite[%0d]", i), 64'(dec_memWrite[i]), 64'(f[5]));
        checkOutput($sformatf("dec_branch[%0d]", i), 64'(dec_branch[i]), 64'(f[6]));
        checkOutput($sformatf("dec_jump[%0d]", i), 64'(dec_jump[i]), 64'(f[7]));
        checkOutput($sformatf("dec_illegal[%0d]", i), 64'(dec_illegal[i]), 64'(f[8]));
      end
      if (after_reset) begin
        checkOutput("rst_dec_pc", 64'(dec_pc), 64'h0);
        checkOutput("rst_dec_instr", 64'(dec_instr), 64'h0);
        checkOutput("rst_dec_ctrl", 64'({dec_immSrc, dec_aluOp, dec_memWrite, dec_branch, dec_jump, dec_illegal}), 64'h0);
      end
    end
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    logic [WIDTH-1:0] v;
    int               k;
    reset_n        = 1'b0;
    flush          = 1'b0;
    dispatch_ready = 1'b0;
    fetch_valid    = '0;
    fetch_instr    = '0;
    fetch_pc       = '0;

    $display("[TB] reset");
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
    checkOutput("reset_dec_valid", 64'(dec_valid), 64'h0);
    checkOutput("reset_fetch_ready", 64'(fetch_ready), 64'h1);

    $display("[TB] single store");
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 4'h2, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 4'h0, 4'h0);
    checkOutput("t1_dec_valid", 64'(dec_valid), 64'h1);
    checkOutput("t1_immSrc0", 64'(dec_immSrc[2:0]), 64'h1);
    checkOutput("t1_aluOp0", 64'(dec_aluOp[1:0]), 64'h1);
    checkOutput("t1_memWrite0", 64'(dec_memWrite[0]), 64'h1);

    $display("[TB] branch and jal pair");
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b11, 4'h3, 4'h5);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
    checkOutput("t2_dec_valid", 64'(dec_valid), 64'h3);
    checkOutput("t2_branch", 64'(dec_branch), 64'h1);
    checkOutput("t2_jump", 64'(dec_jump), 64'h2);
    checkOutput("t2_immSrc", 64'(dec_immSrc), 64'h22);
    checkOutput("t2_aluOp", 64'(dec_aluOp), 64'hd);

    $display("[TB] fill while stalled");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 4'h1, 4'h8);
    checkOutput("t3_ready_at_6", 64'(fetch_ready), 64'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 4'h4, 4'h7);
    checkOutput("t3_ready_full", 64'(fetch_ready), 64'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 4'h6, 4'h0);
    checkOutput("t3_hold_valid", 64'(dec_valid), 64'h3);
    checkOutput("t3_hold_branch", 64'(dec_branch), 64'h1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 4'h0, 4'h0);
    checkOutput("t3_drained", 64'(dec_valid), 64'h0);

    $display("[TB] flush when full");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 4'h2, 4'h3);
    checkOutput("t4_full_ready", 64'(fetch_ready), 64'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, 4'h5, 4'h5);
    checkOutput("t4_flush_valid", 64'(dec_valid), 64'h0);
    checkOutput("t4_flush_ready", 64'(fetch_ready), 64'h1);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 4'h0, 4'h0);
    checkOutput("t4_nothing_left", 64'(dec_valid), 64'h0);

    $display("[TB] unknown opcode");
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b11, 4'hA, 4'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    checkOutput("t5_dec_valid", 64'(dec_valid), 64'h1);
    checkOutput("t5_illegal", 64'(dec_illegal), 64'h1);
`else
    checkOutput("t5_dec_valid", 64'(dec_valid), 64'h3);
    checkOutput("t5_aluOp", 64'(dec_aluOp), 64'h3);
    checkOutput("t5_illegal", 64'(dec_illegal), 64'h0);
`endif
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 4'h0, 4'h0);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 2'b11, 4'h0, 4'h2);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b11, 4'h3, 4'h5);
    checkOutput("t6_dec_valid", 64'(dec_valid), 64'h0);
    checkOutput("t6_dec_ctrl", 64'({dec_immSrc, dec_aluOp, dec_memWrite, dec_branch, dec_jump}), 64'h0);
    checkOutput("t6_fetch_ready", 64'(fetch_ready), 64'h1);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(0, WIDTH);
      v = WIDTH'((1 << k) - 1);
      applyStimulus(($urandom_range(0, 199) != 0), ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 3) != 0), v,
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 4'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 4'h0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
